decoder_onehot_seq: RTL

- Parametrised, registered one-hot decoder for CPU control-signal selection.
- Two modes:
  - Direct: registered decode of a select index.
  - Sequence: built-in step counter that walks the one-hot output through all outputs, one per clock. Used as the T-state timing generator for the control unit.
- Replaces fixed-width combinational 3-to-8 decoding wherever a glitch-free registered select or a timing sequence is needed.

---
 rtl/decoder_onehot_seq_if.sv | 19 +
 rtl/decoder_onehot_seq.sv | 87 ++++++++
 2 files changed

// File: rtl/decoder_onehot_seq_if.sv
// decoder_onehot_seq_if: control/status bundle between a requester and the one-hot decoder/sequencer
interface decoder_onehot_seq_if #(
  parameter int SEL_W = 3,
  parameter int N_OUT = 8
);
  logic             mode;
  logic             en;
  logic [SEL_W-1:0] sel;
  logic             start;
  logic             stop;
  logic [N_OUT-1:0] out;
  logic [SEL_W-1:0] idx;
  logic             valid;
  logic             busy;
  logic             done;
  logic             err;
  modport master (output mode, en, sel, start, stop, input out, idx, valid, busy, done, err);
  modport slave  (input mode, en, sel, start, stop, output out, idx, valid, busy, done, err);
endinterface

// File: rtl/decoder_onehot_seq.sv
// decoder_onehot_seq: registered one-hot decoder with a built-in T-state step sequencer
module decoder_onehot_seq #(
  parameter int SEL_W = 3,
  parameter int N_OUT = 8,
  parameter bit WRAP  = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  decoder_onehot_seq_if.slave  b
);
  if (N_OUT < 2 || N_OUT > (1 << SEL_W)) begin : g_bad_n_out
    $error("decoder_onehot_seq: N_OUT must lie in 2..2**SEL_W");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [SEL_W:0]   N_LIM = (SEL_W+1)'(N_OUT);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_OUT - 1);
  state_t           r_state, w_next;
  logic [N_OUT-1:0] r_out, w_out;
  logic [SEL_W-1:0] r_idx, w_idx;
  logic             r_valid, w_valid, r_busy, w_busy, r_done, w_done, r_err, w_err;
  always_comb begin
    w_next  = r_state;
    w_out   = '0;
    w_idx   = '0;
    w_valid = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      IDLE:
        if (!b.mode) begin
          if (b.en && ({1'b0, b.sel} < N_LIM)) begin
            w_out   = N_OUT'(1) << b.sel;
            w_idx   = b.sel;
            w_valid = 1'b1;
          end else begin
            w_err   = b.en;
          end
        end else if (b.start && !b.stop) begin
          w_next  = RUN;
          w_out   = N_OUT'(1);
          w_valid = 1'b1;
          w_busy  = 1'b1;
        end
      RUN:
        if (b.stop) begin
          w_next = IDLE;
        end else if (r_idx == LAST && !WRAP) begin
          w_next = DONE;
          w_done = 1'b1;
        end else begin
          // last-to-first wrap is explicit so partial ranges (N_OUT < 2**SEL_W) restart at bit 0
          w_out   = (r_idx == LAST) ? N_OUT'(1) : r_out << 1;
          w_idx   = (r_idx == LAST) ? '0 : r_idx + 1'b1;
          w_valid = 1'b1;
          w_busy  = 1'b1;
        end
      default:
        w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_out   <= w_out;
      r_idx   <= w_idx;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end
  assign b.out   = r_out;
  assign b.idx   = r_idx;
  assign b.valid = r_valid;
  assign b.busy  = r_busy;
  assign b.done  = r_done;
  assign b.err   = r_err;
endmodule
